// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - staged active-low reset release gated on stable PLL lock
//   clk          : PLL output clock, only clock of the block
//   resetn       : asynchronous active-low reset
//   lock         : PLL lock flag, asynchronous to clk
//   rst_n_out    : staged active-low resets, bit 0 released first
//   ready        : high while every stage is released
//   pll_rst      : active-high reset request pulse to the PLL
//   relock_count : saturating count of lock losses after release began
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_GAP      = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int PLL_RST_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  lock,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  ready,
    output logic                  pll_rst,
    output logic [7:0]            relock_count
);

    // One shared counter covers every timed phase, so it is sized for the longest.
    localparam int MAX_A   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_B   = (STAGE_GAP > PLL_RST_CYCLES) ? STAGE_GAP : PLL_RST_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        PLL_RST
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            idx          <= '0;
            sync_q       <= '0;
            rst_n_out    <= '0;
            ready        <= 1'b0;
            pll_rst      <= 1'b0;
            relock_count <= 8'd0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state   <= PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    // A glitch here is not a relock event: nothing was released yet.
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE, RUN: begin
                    // Lock loss wins over a release scheduled on the same edge.
                    if (!lock_s) begin
                        rst_n_out <= '0;
                        ready     <= 1'b0;
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        if (relock_count != 8'hFF) begin
                            relock_count <= relock_count + 8'd1;
                        end
                    end else if (state == RELEASE) begin
                        if (cnt == '0) begin
                            rst_n_out[idx] <= 1'b1;
                            idx            <= idx + 1'b1;
                            if (idx == IW'(NUM_STAGES - 1)) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end
                        end
                        cnt <= (cnt == CW'(STAGE_GAP - 1)) ? '0 : cnt + 1'b1;
                    end
                end
                PLL_RST: begin
                    if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                        pll_rst <= 1'b0;
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
